// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the state encoding, owner codes and counter width.
package data_mem_arbiter_pkg;

    typedef enum logic {
        S_SHARED = 1'b0,
        S_BURST  = 1'b1
    } arb_state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DMA  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the core, the DMA engine, the data memory and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface data_mem_arbiter_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   core_re;
    logic                   core_we;
    logic [ADDR_LENGTH-1:0] core_addr;
    logic [DATA_LENGTH-1:0] core_wdata;
    logic [DATA_LENGTH-1:0] core_rdata;
    logic                   core_stall;

    logic                   dma_req;
    logic                   dma_we;
    logic                   dma_burst;
    logic                   dma_last;
    logic [ADDR_LENGTH-1:0] dma_addr;
    logic [DATA_LENGTH-1:0] dma_wdata;
    logic [DATA_LENGTH-1:0] dma_rdata;
    logic                   dma_ack;

    logic [ADDR_LENGTH-1:0] mem_addr;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [DATA_LENGTH-1:0] mem_rdata;

    logic                   owner;

    modport slave (
        input  core_re, core_we, core_addr, core_wdata,
        input  dma_req, dma_we, dma_burst, dma_last, dma_addr, dma_wdata,
        input  mem_rdata,
        output core_rdata, core_stall,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output owner
    );

    modport master (
        output core_re, core_we, core_addr, core_wdata,
        output dma_req, dma_we, dma_burst, dma_last, dma_addr, dma_wdata,
        output mem_rdata,
        input  core_rdata, core_stall,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  owner
    );

endinterface

// File: rtl/data_mem_arbiter_arb_grant_logic.sv
// Combinational grant decision: core priority in shared mode, starvation force,
// and unconditional DMA ownership while a burst is locked.
module arb_grant_logic
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  arb_state_t       st,
    input  logic [CNT_W-1:0] wait_cnt,
    input  logic             core_req,
    input  logic             dma_req,
    output logic             grant_dma,
    output logic             grant_core
);

    logic force_grant;

    assign force_grant = (wait_cnt == CNT_W'(MAX_WAIT));

    always_comb begin
        grant_dma = 1'b0;
        if (st == S_BURST) begin
            grant_dma = dma_req;
        end else begin
            grant_dma = dma_req & (~core_req | force_grant);
        end
        grant_core = core_req & ~grant_dma;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the data-memory port: core load/store path versus DMA,
// with a starvation counter and a bounded locked DMA burst.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int MAX_WAIT    = 4,
    parameter int BURST_MAX   = 8
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);

    arb_state_t       st;
    arb_state_t       st_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_next;
    logic [CNT_W-1:0] beat_inc;

    logic core_req;
    logic grant_dma;
    logic grant_core;
    logic active_dma;
    logic active_core;

    logic [ADDR_LENGTH-1:0] sel_addr;
    logic [DATA_LENGTH-1:0] sel_wdata;

    assign core_req = bus.core_re | bus.core_we;
    assign beat_inc = beat_cnt + CNT_W'(1);

    arb_grant_logic #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .st         (st),
        .wait_cnt   (wait_cnt),
        .core_req   (core_req),
        .dma_req    (bus.dma_req),
        .grant_dma  (grant_dma),
        .grant_core (grant_core)
    );

    // Reset suppresses every grant so no write or ack escapes in the reset cycle.
    assign active_dma  = grant_dma & ~rst;
    assign active_core = grant_core & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_SHARED;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            st       <= st_next;
            wait_cnt <= wait_next;
            beat_cnt <= beat_next;
        end
    end

    always_comb begin
        st_next   = st;
        wait_next = wait_cnt;
        beat_next = beat_cnt;
        case (st)
            S_SHARED: begin
                if (grant_dma) begin
                    wait_next = '0;
                    if (bus.dma_burst && !bus.dma_last && (BURST_MAX > 1)) begin
                        st_next   = S_BURST;
                        beat_next = CNT_W'(1);
                    end
                end else if (bus.dma_req) begin
                    if (wait_cnt < CNT_W'(MAX_WAIT)) begin
                        wait_next = wait_cnt + CNT_W'(1);
                    end
                end else begin
                    wait_next = '0;
                end
            end
            S_BURST: begin
                // A dropped request aborts the burst; the core takes the port at once.
                st_next   = S_SHARED;
                beat_next = '0;
                if (bus.dma_req && !bus.dma_last && (beat_inc != CNT_W'(BURST_MAX))) begin
                    st_next   = S_BURST;
                    beat_next = beat_inc;
                end
            end
            default: begin
                st_next   = S_SHARED;
                beat_next = '0;
            end
        endcase
    end

    always_comb begin
        sel_addr       = bus.core_addr;
        sel_wdata      = bus.core_wdata;
        bus.mem_we     = 1'b0;
        bus.mem_re     = 1'b0;
        bus.dma_ack    = 1'b0;
        bus.owner      = OWNER_CORE;
        bus.core_stall = 1'b0;
        bus.core_rdata = '0;
        bus.dma_rdata  = '0;
        if (active_dma) begin
            sel_addr       = bus.dma_addr;
            sel_wdata      = bus.dma_wdata;
            bus.mem_we     = bus.dma_we;
            bus.mem_re     = ~bus.dma_we;
            bus.dma_ack    = 1'b1;
            bus.owner      = OWNER_DMA;
            bus.core_stall = core_req;
            bus.dma_rdata  = bus.mem_rdata;
        end else if (active_core) begin
            bus.mem_we     = bus.core_we;
            bus.mem_re     = bus.core_re & ~bus.core_we;
            bus.core_rdata = bus.mem_rdata;
        end
    end

    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios then random traffic,
// compared each cycle against a rule-level reference model and a shadow memory.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int AL        = 32;
    localparam int DL        = 32;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    logic mem_clear;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_LENGTH(AL), .DATA_LENGTH(DL)) bus ();

    data_mem_arbiter #(
        .ADDR_LENGTH (AL),
        .DATA_LENGTH (DL),
        .MAX_WAIT    (MAX_WAIT),
        .BURST_MAX   (BURST_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory behind the port: combinational read, synchronous write.
    logic [31:0] mem [0:63];
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    logic [31:0] ref_mem [0:63];
    bit          m_burst;
    int          m_wait;
    int          m_beats;

    logic        last_ack, last_stall, last_owner, last_mem_we, last_mem_re, last_st;
    logic [31:0] last_core_rdata, last_mem_addr;
    int          ack_count, stall_count;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(
        input logic r, input logic cre, input logic cwe,
        input logic [31:0] caddr, input logic [31:0] cwdata,
        input logic dreq, input logic dwe, input logic dburst, input logic dlast,
        input logic [31:0] daddr, input logic [31:0] dwdata
    );
        logic        creq, dg, cg, e_we, e_re;
        logic [31:0] e_addr, e_wdata, e_rd;
        @(negedge clk);
        rst            = r;
        bus.core_re    = cre;
        bus.core_we    = cwe;
        bus.core_addr  = caddr;
        bus.core_wdata = cwdata;
        bus.dma_req    = dreq;
        bus.dma_we     = dwe;
        bus.dma_burst  = dburst;
        bus.dma_last   = dlast;
        bus.dma_addr   = daddr;
        bus.dma_wdata  = dwdata;
        #1;
        creq = cre | cwe;
        if (r)            dg = 1'b0;
        else if (m_burst) dg = dreq;
        else              dg = dreq && (!creq || m_wait >= MAX_WAIT);
        cg      = !r && creq && !dg;
        e_we    = dg ? dwe  : (cg ? cwe : 1'b0);
        e_re    = dg ? !dwe : (cg ? (cre && !cwe) : 1'b0);
        e_addr  = dg ? daddr : caddr;
        e_wdata = dg ? dwdata : cwdata;
        e_rd    = ref_mem[e_addr[7:2]];

        check_output("mem_we", bus.mem_we, e_we);
        check_output("mem_re", bus.mem_re, e_re);
        check_output("dma_ack", bus.dma_ack, dg);
        check_output("owner", bus.owner, dg);
        check_output("core_stall", bus.core_stall, dg && creq);
        check_output("core_rdata", bus.core_rdata, cg ? e_rd : 32'h0);
        check_output("dma_rdata", bus.dma_rdata, dg ? e_rd : 32'h0);
        if (!r) check_output("mem_addr", bus.mem_addr, e_addr);
        if (dg || cg) check_output("mem_wdata", bus.mem_wdata, e_wdata);

        last_ack        = bus.dma_ack;
        last_stall      = bus.core_stall;
        last_owner      = bus.owner;
        last_mem_we     = bus.mem_we;
        last_mem_re     = bus.mem_re;
        last_core_rdata = bus.core_rdata;
        last_mem_addr   = bus.mem_addr;
        last_st         = dut.st;
        ack_count       += int'(bus.dma_ack);
        stall_count     += int'(bus.core_stall);

        @(posedge clk);
        if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
        if (r) begin
            m_burst = 0; m_wait = 0; m_beats = 0;
        end else if (m_burst) begin
            if (dreq) begin
                m_beats++;
                if (dlast || m_beats == BURST_MAX) begin
                    m_burst = 0; m_beats = 0;
                end
            end else begin
                m_burst = 0; m_beats = 0;
            end
        end else if (dg) begin
            m_wait = 0;
            if (dburst && !dlast && BURST_MAX > 1) begin
                m_burst = 1; m_beats = 1;
            end
        end else if (dreq) begin
            m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        end else begin
            m_wait = 0;
        end
    endtask

    initial begin
        logic        r_rst, r_cre, r_cwe, r_dreq, r_dwe, r_db, r_dl;
        logic [31:0] r_ca, r_da;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        m_burst = 0; m_wait = 0; m_beats = 0;
        mem_clear = 1'b1;
        rst = 1'b1;
        bus.core_re = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_burst = 0; bus.dma_last = 0;
        bus.dma_addr = 0; bus.dma_wdata = 0;
        @(posedge clk);
        #1 mem_clear = 1'b0;

        // Reset with both masters requesting
        for (int i = 0; i < 2; i++)
            apply_stimulus(1, 0, 1, 32'h08, 32'h1111_1111, 1, 1, 0, 0, 32'h0C, 32'h2222_2222);
        check_output("t1_mem_we", last_mem_we, 1'b0);
        check_output("t1_ack", last_ack, 1'b0);
        check_output("t1_stall", last_stall, 1'b0);
        check_output("t1_owner", last_owner, 1'b0);

        // Starvation force under continuous core reads
        ack_count = 0;
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 32'h10, 32'h0);
        check_output("t2_no_early_ack", ack_count, 0);
        apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 32'h10, 32'h0);
        check_output("t2_forced_ack", last_ack, 1'b1);
        check_output("t2_forced_stall", last_stall, 1'b1);
        check_output("t2_forced_addr", last_mem_addr, 32'h10);
        apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 32'h10, 32'h0);
        check_output("t2_core_back", last_stall, 1'b0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Idle-core DMA write, then core reads it back
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h04, 32'hDEAD_BEEF);
        check_output("t3_ack", last_ack, 1'b1);
        check_output("t3_mem_we", last_mem_we, 1'b1);
        apply_stimulus(0, 1, 0, 32'h04, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_output("t3_readback", last_core_rdata, 32'hDEAD_BEEF);

        // Burst ended by dma_last with the core store held
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 0, 1, 32'h08, 32'h1234_5678, 1, 0, 1, 0, 32'h0C, 32'h0);
        ack_count = 0; stall_count = 0;
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 1, 32'h08, 32'h1234_5678, 1, 0, 1, (i == 2), 32'h0C, 32'h0);
        apply_stimulus(0, 0, 1, 32'h08, 32'h1234_5678, 0, 0, 0, 0, 32'h0, 32'h0);
        check_output("t4_acks", ack_count, 3);
        check_output("t4_stalls", stall_count, 3);
        check_output("t4_store_done", last_mem_we, 1'b1);

        // Burst capped at BURST_MAX beats
        ack_count = 0;
        for (int i = 0; i < 4 + BURST_MAX; i++)
            apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, 1, 0, 32'h14, 32'h0);
        check_output("t5_acks", ack_count, BURST_MAX);
        apply_stimulus(0, 1, 0, 32'h20, 32'h0, 1, 0, 1, 0, 32'h14, 32'h0);
        check_output("t5_core_granted", last_mem_re, 1'b1);
        check_output("t5_no_ack", last_ack, 1'b0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Abort on beat 2
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 32'h18, 32'h0);
        apply_stimulus(0, 1, 0, 32'h30, 32'h0, 0, 0, 0, 0, 32'h18, 32'h0);
        check_output("t6_abort_ack", last_ack, 1'b0);
        check_output("t6_abort_core", last_mem_re, 1'b1);
        check_output("t6_abort_owner", last_owner, 1'b0);

        // Reset on beat 2
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 32'h1C, 32'hABCD_0001);
        apply_stimulus(1, 0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 32'h1C, 32'hABCD_0002);
        check_output("t6_rst_ack", last_ack, 1'b0);
        check_output("t6_rst_we", last_mem_we, 1'b0);
        apply_stimulus(0, 1, 0, 32'h1C, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
        check_output("t6_rst_owner", last_owner, 1'b0);
        check_output("t6_rst_st", 32'(last_st), 32'(S_SHARED));
        check_output("t6_rst_rdata", last_core_rdata, 32'hABCD_0001);

        // Random mixed traffic
        for (int n = 0; n < 400; n++) begin
            r_rst  = ($urandom_range(0, 49) == 0);
            r_cre  = $urandom_range(0, 1);
            r_cwe  = ($urandom_range(0, 3) == 0);
            r_dreq = ($urandom_range(0, 9) < 7);
            r_dwe  = $urandom_range(0, 1);
            r_db   = ($urandom_range(0, 9) < 3);
            r_dl   = ($urandom_range(0, 3) == 0);
            r_ca   = 32'($urandom_range(0, 63)) << 2;
            r_da   = 32'($urandom_range(0, 63)) << 2;
            apply_stimulus(r_rst, r_cre, r_cwe, r_ca, $urandom, r_dreq, r_dwe, r_db, r_dl, r_da, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-master arbiter sharing the single data-memory port (Data_Memory behind the memory map decoder) between the core load/store path and a DMA engine (UART-RX buffer drain).
- The core has priority. A starvation counter guarantees the DMA a slot. The DMA can also lock the port for a bounded burst.
- The block drives core_stall, which gates the PC register enable so that a denied core access is replayed on the next cycle.

Parameters:
- ADDR_LENGTH, 32, address width of both masters and the memory port.
- DATA_LENGTH, 32, data width.
- MAX_WAIT, 4, consecutive denied DMA cycles before the DMA is forced a grant. Legal range 1..15.
- BURST_MAX, 8, maximum beats in one locked DMA burst. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- core_re  in  1  core load request (CU MemRead, gated by decoder Select0)
- core_we  in  1  core store request
- core_addr  in  ADDR_LENGTH  core address (ALUResult)
- core_wdata  in  DATA_LENGTH  core store data (rd2)
- core_rdata  out  DATA_LENGTH  load data to the core
- core_stall  out  1  core access denied this cycle; PC must hold
- dma_req  in  1  DMA beat request
- dma_we  in  1  1 = write beat, 0 = read beat
- dma_burst  in  1  request a locked burst (sampled on the first granted beat)
- dma_last  in  1  current beat is the last of the burst
- dma_addr  in  ADDR_LENGTH  DMA address
- dma_wdata  in  DATA_LENGTH  DMA write data
- dma_rdata  out  DATA_LENGTH  read data to the DMA
- dma_ack  out  1  DMA beat performed this cycle
- mem_addr  out  ADDR_LENGTH  to memory
- mem_wdata  out  DATA_LENGTH  to memory
- mem_we  out  1  to memory
- mem_re  out  1  to memory
- mem_rdata  in  DATA_LENGTH  from memory (combinational read)
- owner  out  1  0 = core, 1 = DMA (debug/display)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Memory timing: memory read is combinational and write is synchronous. One beat per cycle. Grant is combinational from the current requests and the registered state.

Registered state:
- st ∈ {S_SHARED, S_BURST}
- wait_cnt: 4 bits
- beat_cnt: 4 bits

Reset:
- On reset, st=S_SHARED, wait_cnt=0, beat_cnt=0.
- While rst=1, all outputs are forced inactive: mem_we=0, mem_re=0, dma_ack=0, core_stall=0, owner=0, and the rdata outputs are 0.

Definitions:
- core_req = core_re | core_we.
- If core_re and core_we are both high, treat the access as a write.

S_SHARED:
- force = (wait_cnt == MAX_WAIT).
- DMA granted when dma_req & (!core_req | force). Otherwise the core is granted when core_req.
- DMA granted: dma_ack=1, owner=1, memory driven from the dma_* ports, core_stall=core_req, wait_cnt←0.
  - If dma_burst & !dma_last & BURST_MAX>1: st←S_BURST, beat_cnt←1.
- Core granted with dma_req pending: wait_cnt←wait_cnt+1, saturating at MAX_WAIT.
- No dma_req: wait_cnt←0.

S_BURST:
- DMA owns the port and core_stall=core_req.
- dma_req=1: beat performed, dma_ack=1, beat_cnt←beat_cnt+1.
  - If dma_last or beat_cnt+1 == BURST_MAX: st←S_SHARED, beat_cnt←0.
- dma_req=0 (DMA aborts): no ack, st←S_SHARED, beat_cnt←0, and the core is granted in that same cycle.

Outputs:
- mem_re = granted master's read.
- mem_we = granted master's write.
- No master granted: mem_re=mem_we=0, mem_addr = core_addr (no side effect).
- core_rdata = mem_rdata when the core is granted, else 0.
- dma_rdata = mem_rdata when dma_ack, else 0.

Boundaries:
- MAX_WAIT bounds DMA latency to MAX_WAIT+1 cycles under continuous core traffic.
- A burst bounds core stall to BURST_MAX cycles.
- A forced DMA grant while the core requests produces exactly one stall cycle.
- Reset mid-burst returns the block to S_SHARED on the next edge. No ack or write is issued in the reset cycle.

Decomposition:
- Shared package: state encoding (S_SHARED=0, S_BURST=1), OWNER_CORE/OWNER_DMA constants, counter width localparam (4).
- Sub-module: arb_grant_logic, containing the combinational grant/force decision. Counters and the FSM stay in the top module.

Test Plan:
1. Reset: rst=1 for 2 cycles with core_we=1 and dma_req=1 → mem_we=0, dma_ack=0, core_stall=0, owner=0.
2. Core priority / starvation:
   - Stimulus: core_re=1 every cycle, dma_req=1 read at addr 0x10, MAX_WAIT=4.
   - Response: core granted for 4 cycles. 5th cycle dma_ack=1, core_stall=1, mem_addr=0x10. Next cycle the core is granted again.
3. Idle-core DMA write:
   - Stimulus: core idle, dma_req=1, dma_we=1, addr 0x04, data 0xDEADBEEF.
   - Response: same-cycle dma_ack=1, mem_we=1. A subsequent core_re at 0x04 returns core_rdata=0xDEADBEEF.
4. Burst with dma_last:
   - Stimulus: dma_burst=1, dma_last on beat 3, core_we held high.
   - Response: 3 consecutive acks, core_stall=1 for 3 cycles, core store completes on cycle 4.
5. BURST_MAX cap: burst with dma_last never asserted, BURST_MAX=8 → acks on 8 cycles, then st returns to S_SHARED and the pending core access is granted.
6. Abort and reset mid-burst:
   - Abort: dma_req drops on beat 2 → no ack, core granted in that cycle.
   - Reset: rst asserted on beat 2 → no ack, and the next cycle shows owner=0, st=S_SHARED.
